hb_task_dispatcher: RTL

Downstream consumer of `hb_task_queue_core`: watches the queue head (`valid_out`/`data_out`), pops one task per cycle when a worker can take it, and routes it to one of `NUM_WORKERS` worker lanes under per-worker credit flow control. Unpinned tasks go round-robin to workers with credit. Pinned tasks go only to their named worker and block the head until that worker has credit. A quiesce handshake lets the host stop dispatch and wait for all outstanding work to drain.

---
 rtl/hb_task_pkg.sv | 25 ++
 rtl/hb_rr_credit_pick.sv | 34 +++
 rtl/hb_task_dispatcher.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hb_task_pkg.sv
// Shared task-word layout and dispatcher state encoding for the task dispatcher slice.
package hb_task_pkg;

    localparam int TASK_PIN_BIT = 31;
    localparam int TASK_TGT_HI  = 29;
    localparam int TASK_TGT_LO  = 28;

    typedef logic [31:0] hb_task_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HOL_STALL,
        ST_DRAIN,
        ST_QUIESCED
    } disp_state_e;

    function automatic logic task_pinned(input hb_task_t t);
        return t[TASK_PIN_BIT];
    endfunction

    function automatic logic [1:0] task_target(input hb_task_t t);
        return t[TASK_TGT_HI:TASK_TGT_LO];
    endfunction

endpackage

// File: rtl/hb_rr_credit_pick.sv
// Combinational round-robin picker: first set mask bit searching upward from rr_ptr+1 with wrap.
module hb_rr_credit_pick #(
    parameter int NUM_WORKERS = 4,
    parameter int IW          = $clog2(NUM_WORKERS)
) (
    input  logic [IW-1:0]          rr_ptr,
    input  logic [NUM_WORKERS-1:0] mask,
    output logic [IW-1:0]          grant_idx,
    output logic                   grant_valid
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest eligible worker wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        idx         = '0;
        for (int k = NUM_WORKERS; k >= 1; k--) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_WORKERS)) begin
                sum = sum - (IW+1)'(NUM_WORKERS);
            end
            idx = sum[IW-1:0];
            if (mask[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/hb_task_dispatcher.sv
// Pops tasks from the queue head and routes them to worker lanes under per-worker credits.
module hb_task_dispatcher
    import hb_task_pkg::*;
#(
    parameter int NUM_WORKERS = 4,
    parameter int CREDITS     = 2,
    parameter int STAT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   q_valid,
    input  logic [31:0]            q_data,
    output logic                   q_pop,
    output logic [NUM_WORKERS-1:0] task_valid,
    output logic [31:0]            task_data,
    input  logic [NUM_WORKERS-1:0] credit_return,
    input  logic                   quiesce_req,
    output logic                   quiesced,
    output logic                   err_credit_ovf,
    output logic [STAT_W-1:0]      stat_dispatched,
    output logic [STAT_W-1:0]      stat_hol_stall
);

    localparam int IW = $clog2(NUM_WORKERS);
    localparam int CW = $clog2(CREDITS + 1);

    disp_state_e              state_reg;
    logic [IW-1:0]            rr_ptr_reg;
    logic [NUM_WORKERS-1:0]   task_valid_reg;
    hb_task_t                 task_data_reg;
    logic                     err_reg;
    logic [STAT_W-1:0]        stat_disp_reg;
    logic [STAT_W-1:0]        stat_hol_reg;

    logic [NUM_WORKERS-1:0]   elig;
    logic [NUM_WORKERS-1:0]   full_next;
    logic [NUM_WORKERS-1:0]   ovf_hit;
    logic [NUM_WORKERS-1:0]   tgt_hit;
    logic [NUM_WORKERS-1:0]   grant_oh;
    logic [1:0]               pin_tgt;
    logic                     pinned;
    logic [IW-1:0]            pin_idx;
    logic [IW-1:0]            pick_idx;
    logic                     pick_valid;
    logic [IW-1:0]            cand_idx;
    logic                     cand_valid;
    logic                     head_blocked;
    logic                     dispatch_ok;

    assign pin_tgt = task_target(q_data);
    assign pin_idx = IW'(pin_tgt);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORKERS; gi++) begin : g_tgt
            assign tgt_hit[gi] = (pin_tgt == 2'(gi));
        end
    endgenerate

    // A target outside the worker range matches no lane, so the head falls back to round-robin.
    assign pinned = task_pinned(q_data) && (|tgt_hit);

    hb_rr_credit_pick #(
        .NUM_WORKERS (NUM_WORKERS),
        .IW          (IW)
    ) u_pick (
        .rr_ptr      (rr_ptr_reg),
        .mask        (elig),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    assign cand_valid   = pinned ? (|(tgt_hit & elig)) : pick_valid;
    assign cand_idx     = pinned ? pin_idx : pick_idx;
    assign head_blocked = q_valid && pinned && !cand_valid;
    assign dispatch_ok  = ((state_reg == ST_RUN) || (state_reg == ST_HOL_STALL)) && !quiesce_req;
    assign q_pop        = q_valid && cand_valid && dispatch_ok;

    generate
        for (gi = 0; gi < NUM_WORKERS; gi++) begin : g_cred
            logic [CW-1:0] cred_reg;
            logic [CW-1:0] cred_next;
            logic          ovf_now;

            assign grant_oh[gi] = q_pop && (cand_idx == IW'(gi));

            always_comb begin
                cred_next = cred_reg;
                ovf_now   = 1'b0;
                if (grant_oh[gi] && !credit_return[gi]) begin
                    cred_next = cred_reg - CW'(1);
                end else if (credit_return[gi] && !grant_oh[gi]) begin
                    if (cred_reg == CW'(CREDITS)) begin
                        ovf_now = 1'b1;
                    end else begin
                        cred_next = cred_reg + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cred_reg <= CW'(CREDITS);
                end else begin
                    cred_reg <= cred_next;
                end
            end

            assign elig[gi]      = (cred_reg != '0);
            assign full_next[gi] = (cred_next == CW'(CREDITS));
            assign ovf_hit[gi]   = ovf_now;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_RUN;
            rr_ptr_reg     <= IW'(NUM_WORKERS - 1);
            task_valid_reg <= '0;
            task_data_reg  <= '0;
            err_reg        <= 1'b0;
            stat_disp_reg  <= '0;
            stat_hol_reg   <= '0;
        end else begin
            task_valid_reg <= grant_oh;
            err_reg        <= err_reg | (|ovf_hit);
            if (q_pop) begin
                task_data_reg <= q_data;
                rr_ptr_reg    <= cand_idx;
                stat_disp_reg <= stat_disp_reg + STAT_W'(1);
            end

            case (state_reg)
                ST_RUN: begin
                    if (quiesce_req) begin
                        state_reg <= ST_DRAIN;
                    end else if (head_blocked) begin
                        state_reg <= ST_HOL_STALL;
                    end
                end
                ST_HOL_STALL: begin
                    // The releasing cycle dispatches, so only non-dispatching cycles are stalls.
                    if (!q_pop) begin
                        stat_hol_reg <= stat_hol_reg + STAT_W'(1);
                    end
                    if (quiesce_req) begin
                        state_reg <= ST_DRAIN;
                    end else if (!head_blocked) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    // Look at next-cycle credits so quiesced rises right after the last return.
                    if (!quiesce_req) begin
                        state_reg <= ST_RUN;
                    end else if (&full_next) begin
                        state_reg <= ST_QUIESCED;
                    end
                end
                ST_QUIESCED: begin
                    if (!quiesce_req) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    assign task_valid      = task_valid_reg;
    assign task_data       = task_data_reg;
    assign quiesced        = (state_reg == ST_QUIESCED);
    assign err_credit_ovf  = err_reg;
    assign stat_dispatched = stat_disp_reg;
    assign stat_hol_stall  = stat_hol_reg;

endmodule
